// File: rtl/pacman_pkg.sv
// ----------------------------------------------------------------------------
// pacman_pkg : direction/state types and keycode decode for sprite motion
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pacman_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_TRY       = 4'd2,
        S_WAIT_TRY  = 4'd3,
        S_CONT      = 4'd4,
        S_WAIT_CONT = 4'd5,
        S_COMMIT    = 4'd6,
        S_STOP      = 4'd7,
        S_DONE      = 4'd8
    } motion_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    // Unmapped keys keep the sprite heading where it already goes.
    function automatic dir_t decode_key(input logic [7:0] key, input dir_t cur);
        case (key)
            KEY_W:   return DIR_UP;
            KEY_S:   return DIR_DOWN;
            KEY_A:   return DIR_LEFT;
            KEY_D:   return DIR_RIGHT;
            default: return cur;
        endcase
    endfunction

    function automatic dir_t sanitize_dir(input logic [2:0] raw, input dir_t cur);
        case (raw)
            3'd1, 3'd2, 3'd3, 3'd4: return dir_t'(raw);
            default:                return cur;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_step_calc.sv
// ----------------------------------------------------------------------------
// sprite_step_calc : candidate position one STEP along dir, with bounds check
// Optional macro   : TUNNEL_WRAP_EN (X wraps around the playfield edges)
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sprite_step_calc
    import pacman_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int STEP    = 1
) (
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic               in_bounds
);

    localparam logic signed [COORD_W:0] C_X_MIN = (COORD_W+1)'(X_MIN);
    localparam logic signed [COORD_W:0] C_X_MAX = (COORD_W+1)'(X_MAX);
    localparam logic signed [COORD_W:0] C_Y_MIN = (COORD_W+1)'(Y_MIN);
    localparam logic signed [COORD_W:0] C_Y_MAX = (COORD_W+1)'(Y_MAX);
    localparam logic signed [COORD_W:0] C_STEP  = (COORD_W+1)'(STEP);

    logic signed [COORD_W:0] w_nx;
    logic signed [COORD_W:0] w_ny;
    logic                    w_x_ok;
    logic                    w_y_ok;

    // One extra signed bit so a step below zero is seen as negative, not a large value.
    always_comb begin
        w_nx = $signed({1'b0, pos_x});
        w_ny = $signed({1'b0, pos_y});
        case (dir)
            DIR_UP:    w_ny = w_ny - C_STEP;
            DIR_DOWN:  w_ny = w_ny + C_STEP;
            DIR_LEFT:  w_nx = w_nx - C_STEP;
            DIR_RIGHT: w_nx = w_nx + C_STEP;
            default:   ;
        endcase
        w_x_ok = (w_nx >= C_X_MIN) && (w_nx <= C_X_MAX);
        w_y_ok = (w_ny >= C_Y_MIN) && (w_ny <= C_Y_MAX);
        cand_x = w_nx[COORD_W-1:0];
        cand_y = w_ny[COORD_W-1:0];
`ifdef TUNNEL_WRAP_EN
        if (w_nx < C_X_MIN) begin
            cand_x = COORD_W'(X_MAX);
            w_x_ok = 1'b1;
        end else if (w_nx > C_X_MAX) begin
            cand_x = COORD_W'(X_MIN);
            w_x_ok = 1'b1;
        end
`endif
        in_bounds = w_x_ok && w_y_ok;
    end

endmodule

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// ----------------------------------------------------------------------------
// sprite_motion_ctrl : per-frame maze motion engine with wall-query cornering
// Optional macro     : TUNNEL_WRAP_EN (horizontal tunnel wrap in step calc)
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sprite_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int STEP        = 1,
    parameter int HOME_X      = 320,
    parameter int HOME_Y      = 240,
    parameter int HOME_DX     = 16
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           vs,
    input  logic [7:0]                     keycode,
    input  logic [3*NUM_SPRITES-1:0]       dir_req,
    output logic                           wall_req,
    output logic [COORD_W-1:0]             wall_x,
    output logic [COORD_W-1:0]             wall_y,
    input  logic                           wall_ack,
    input  logic                           wall_hit,
    output logic [COORD_W*NUM_SPRITES-1:0] pos_x,
    output logic [COORD_W*NUM_SPRITES-1:0] pos_y,
    output logic [3*NUM_SPRITES-1:0]       cur_dir,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int               IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    motion_state_t      r_state;
    logic [IDX_W-1:0]   r_idx;
    dir_t               r_req_dir;
    dir_t               r_commit_dir;
    logic               r_vs_sync;
    logic               r_vs_prev;
    logic [COORD_W-1:0] r_pos_x [NUM_SPRITES];
    logic [COORD_W-1:0] r_pos_y [NUM_SPRITES];
    dir_t               r_dir   [NUM_SPRITES];

    logic               w_tick;
    dir_t               w_cur_dir;
    dir_t               w_request;
    dir_t               w_calc_dir;
    logic [COORD_W-1:0] w_cand_x;
    logic [COORD_W-1:0] w_cand_y;
    logic               w_in_bounds;

    assign w_tick     = r_vs_prev & ~r_vs_sync;
    assign w_cur_dir  = r_dir[r_idx];
    assign w_calc_dir = (r_state == S_CONT) ? w_cur_dir : r_req_dir;

    always_comb begin
        w_request = sanitize_dir(dir_req[int'(r_idx)*3 +: 3], w_cur_dir);
        if (r_idx == '0) begin
            w_request = decode_key(keycode, w_cur_dir);
        end
    end

    sprite_step_calc #(
        .COORD_W (COORD_W),
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX),
        .STEP    (STEP)
    ) u_step (
        .pos_x     (r_pos_x[r_idx]),
        .pos_y     (r_pos_y[r_idx]),
        .dir       (w_calc_dir),
        .cand_x    (w_cand_x),
        .cand_y    (w_cand_y),
        .in_bounds (w_in_bounds)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_req_dir    <= DIR_NONE;
            r_commit_dir <= DIR_NONE;
            r_vs_sync    <= 1'b1;
            r_vs_prev    <= 1'b1;
            wall_req     <= 1'b0;
            wall_x       <= '0;
            wall_y       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pos_x[i] <= COORD_W'(HOME_X + i * HOME_DX);
                r_pos_y[i] <= COORD_W'(HOME_Y);
                r_dir[i]   <= DIR_NONE;
            end
        end else begin
            r_vs_sync  <= vs;
            r_vs_prev  <= r_vs_sync;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            if (w_tick && busy) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_tick) begin
                        busy    <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_req_dir <= w_request;
                    r_state   <= S_TRY;
                end
                S_TRY: begin
                    if (r_req_dir == DIR_NONE) begin
                        r_state <= S_STOP;
                    end else if (!w_in_bounds) begin
                        r_state <= S_CONT;
                    end else begin
                        wall_req <= 1'b1;
                        wall_x   <= w_cand_x;
                        wall_y   <= w_cand_y;
                        r_state  <= S_WAIT_TRY;
                    end
                end
                S_WAIT_TRY: begin
                    if (wall_ack) begin
                        wall_req <= 1'b0;
                        if (!wall_hit) begin
                            r_commit_dir <= r_req_dir;
                            r_state      <= S_COMMIT;
                        end else begin
                            r_state <= S_CONT;
                        end
                    end
                end
                S_CONT: begin
                    if ((r_req_dir == w_cur_dir) || (w_cur_dir == DIR_NONE) || !w_in_bounds) begin
                        r_state <= S_STOP;
                    end else begin
                        wall_req <= 1'b1;
                        wall_x   <= w_cand_x;
                        wall_y   <= w_cand_y;
                        r_state  <= S_WAIT_CONT;
                    end
                end
                S_WAIT_CONT: begin
                    if (wall_ack) begin
                        wall_req <= 1'b0;
                        if (!wall_hit) begin
                            r_commit_dir <= w_cur_dir;
                            r_state      <= S_COMMIT;
                        end else begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_COMMIT, S_STOP: begin
                    // The accepted candidate is still held on wall_x/wall_y from its query.
                    if (r_state == S_COMMIT) begin
                        r_pos_x[r_idx] <= wall_x;
                        r_pos_y[r_idx] <= wall_y;
                        r_dir[r_idx]   <= r_commit_dir;
                    end else begin
                        r_dir[r_idx] <= DIR_NONE;
                    end
                    if (r_idx == C_LAST_IDX) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
        assign pos_x[g*COORD_W +: COORD_W] = r_pos_x[g];
        assign pos_y[g*COORD_W +: COORD_W] = r_pos_y[g];
        assign cur_dir[g*3 +: 3]           = r_dir[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sprite_motion_ctrl : table vectors + wall-query scoreboard for the motion engine
// Revision              : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_motion_ctrl;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int D_NONE = 0, D_UP = 1, D_DOWN = 2, D_LEFT = 3, D_RIGHT = 4;

    logic            clk;
    logic            rst_n;
    logic            vs;
    logic [7:0]      keycode;
    logic [3*N-1:0]  dir_req;
    logic            wall_req;
    logic [CW-1:0]   wall_x;
    logic [CW-1:0]   wall_y;
    logic            wall_ack;
    logic            wall_hit;
    logic [CW*N-1:0] pos_x;
    logic [CW*N-1:0] pos_y;
    logic [3*N-1:0]  cur_dir;
    logic            busy;
    logic            frame_done;
    logic            overrun;

    sprite_motion_ctrl dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .vs         (vs),
        .keycode    (keycode),
        .dir_req    (dir_req),
        .wall_req   (wall_req),
        .wall_x     (wall_x),
        .wall_y     (wall_y),
        .wall_ack   (wall_ack),
        .wall_hit   (wall_hit),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .cur_dir    (cur_dir),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } query_t;

    typedef struct {
        logic [7:0]     key;
        logic [3*N-1:0] dreq;
        int             nblk;
        int             bx0, by0, bx1, by1;
        int             ex, ey, ed, eacks;
    } vec_t;

    query_t exp_q[$];
    vec_t   vecs[6];
    int     n_tests, n_fail;
    int     m_x[N], m_y[N], m_d[N];
    int     blk_x[2], blk_y[2], blk_n;
    int     ack_count, ack_delay, wait_cnt;
    bit     ack_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_blocked(input int x, input int y);
        for (int i = 0; i < blk_n; i++)
            if (blk_x[i] == x && blk_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int key_dir(input logic [7:0] k, input int cur);
        case (k)
            8'h1A:   return D_UP;
            8'h16:   return D_DOWN;
            8'h04:   return D_LEFT;
            8'h07:   return D_RIGHT;
            default: return cur;
        endcase
    endfunction

    function automatic bit cand(input int x, input int y, input int d, output int cx, output int cy);
        bit ox, oy;
        cx = x;
        cy = y;
        if (d == D_UP)    cy = y - 1;
        if (d == D_DOWN)  cy = y + 1;
        if (d == D_LEFT)  cx = x - 1;
        if (d == D_RIGHT) cx = x + 1;
        ox = (cx >= 0) && (cx <= 639);
        oy = (cy >= 0) && (cy <= 479);
`ifdef TUNNEL_WRAP_EN
        if (cx < 0)   begin cx = 639; ox = 1'b1; end
        if (cx > 639) begin cx = 0;   ox = 1'b1; end
`endif
        return ox && oy;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 320 + 16 * i;
            m_y[i] = 240;
            m_d[i] = D_NONE;
        end
    endtask

    // Expected outcome of one frame; every wall query it predicts goes on exp_q.
    task automatic model_frame();
        int req, cx, cy;
        logic [2:0] raw;
        for (int i = 0; i < N; i++) begin
            raw = dir_req[i*3 +: 3];
            if (i == 0) req = key_dir(keycode, m_d[i]);
            else        req = (raw >= 3'd1 && raw <= 3'd4) ? int'(raw) : m_d[i];
            if (req == D_NONE) begin m_d[i] = D_NONE; continue; end
            if (cand(m_x[i], m_y[i], req, cx, cy)) begin
                exp_q.push_back('{cx, cy});
                if (!is_blocked(cx, cy)) begin
                    m_x[i] = cx; m_y[i] = cy; m_d[i] = req;
                    continue;
                end
            end
            if (req == m_d[i] || m_d[i] == D_NONE) begin m_d[i] = D_NONE; continue; end
            if (cand(m_x[i], m_y[i], m_d[i], cx, cy)) begin
                exp_q.push_back('{cx, cy});
                if (!is_blocked(cx, cy)) begin
                    m_x[i] = cx; m_y[i] = cy;
                    continue;
                end
            end
            m_d[i] = D_NONE;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(pos_x[i*CW +: CW]), m_x[i]);
            check($sformatf("%s_y%0d", tag, i), 32'(pos_y[i*CW +: CW]), m_y[i]);
            check($sformatf("%s_dir%0d", tag, i), 32'(cur_dir[i*3 +: 3]), m_d[i]);
        end
        check($sformatf("%s_queries_left", tag), exp_q.size(), 0);
    endtask

    task automatic pulse_vs();
        @(negedge clk) vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!frame_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_frame_done", tag), 32'(frame_done), 1);
    endtask

    task automatic run_frame(input string tag);
        model_frame();
        pulse_vs();
        wait_done(tag);
        check_model(tag);
    endtask

    task automatic wait_req_high(input string tag);
        int t = 0;
        while (!wall_req && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_req_seen", tag), 32'(wall_req), 1);
    endtask

    // Wall lookup model: answers queries after a random 0..2 cycle delay.
    initial begin
        query_t e;
        wall_ack = 1'b0;
        wall_hit = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (wall_ack) begin
                wall_ack = 1'b0;
                wall_hit = 1'b0;
                wait_cnt = 0;
                check("req_drop_after_ack", 32'(wall_req), 0);
            end else if (wall_req && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    wall_ack = 1'b1;
                    wall_hit = is_blocked(int'(wall_x), int'(wall_y));
                    ack_count++;
                    ack_delay = $urandom_range(0, 2);
                    if (exp_q.size() == 0) begin
                        check("query_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("query_x", 32'(wall_x), e.x);
                        check("query_y", 32'(wall_y), e.y);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr_cnt, fd_cnt;
        n_tests = 0; n_fail = 0;
        ack_en = 1'b1; ack_delay = 0; ack_count = 0; blk_n = 0;
        rst_n = 1'b0; vs = 1'b1; keycode = 8'h00; dir_req = '0;

        vecs[0] = '{8'h07, 12'h000, 0, 0, 0, 0, 0, 321, 240, D_RIGHT, 1};
        vecs[1] = '{8'h1A, 12'h000, 1, 321, 239, 0, 0, 322, 240, D_RIGHT, 2};
        vecs[2] = '{8'h00, 12'hE58, 0, 0, 0, 0, 0, 323, 240, D_RIGHT, 3};
        vecs[3] = '{8'h16, 12'h000, 2, 323, 241, 324, 240, 323, 240, D_NONE, 4};
        vecs[4] = '{8'h04, 12'h000, 1, 322, 240, 0, 0, 323, 240, D_NONE, 3};
        vecs[5] = '{8'h1A, 12'h000, 0, 0, 0, 0, 0, 323, 239, D_UP, 3};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wall_req", 32'(wall_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check_model("rst");

        foreach (vecs[v]) begin
            blk_n = vecs[v].nblk;
            blk_x[0] = vecs[v].bx0; blk_y[0] = vecs[v].by0;
            blk_x[1] = vecs[v].bx1; blk_y[1] = vecs[v].by1;
            keycode = vecs[v].key;
            dir_req = vecs[v].dreq;
            ack_count = 0;
            run_frame($sformatf("vec%0d", v));
            check($sformatf("vec%0d_x0", v), 32'(pos_x[CW-1:0]), vecs[v].ex);
            check($sformatf("vec%0d_y0", v), 32'(pos_y[CW-1:0]), vecs[v].ey);
            check($sformatf("vec%0d_dir0", v), 32'(cur_dir[2:0]), vecs[v].ed);
            check($sformatf("vec%0d_acks", v), ack_count, vecs[v].eacks);
        end

        // Walk pacman to the left edge; ghost 1 runs into the top edge on the way.
        blk_n = 0; keycode = 8'h04; dir_req = '0;
        for (int f = 0; f < 323; f++) run_frame("walk");
        check("edge_x0", 32'(pos_x[CW-1:0]), 0);
        check("edge_dir0", 32'(cur_dir[2:0]), D_LEFT);
        ack_count = 0;
        run_frame("edge");
`ifdef TUNNEL_WRAP_EN
        check("wrap_x0", 32'(pos_x[CW-1:0]), 639);
        check("wrap_dir0", 32'(cur_dir[2:0]), D_LEFT);
        check("wrap_acks", ack_count, 2);
`else
        check("edge_stop_x0", 32'(pos_x[CW-1:0]), 0);
        check("edge_stop_dir0", 32'(cur_dir[2:0]), D_NONE);
        check("edge_stop_acks", ack_count, 1);
`endif

        // Second frame tick while the first query is still unanswered.
        keycode = 8'h07; ack_en = 1'b0;
        model_frame();
        pulse_vs();
        wait_req_high("ovr");
        ovr_cnt = 0; fd_cnt = 0;
        vs = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 3)  vs = 1'b1;
            if (c == 20) ack_en = 1'b1;
            if (overrun)    ovr_cnt++;
            if (frame_done) fd_cnt++;
        end
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_frame_done_count", fd_cnt, 1);
        check_model("ovr");

        // Reset while a query is pending.
        ack_en = 1'b0;
        pulse_vs();
        wait_req_high("rst_mid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wall_req", 32'(wall_req), 0);
        check("rst_mid_busy", 32'(busy), 0);
        exp_q.delete();
        model_reset();
        check_model("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        keycode = 8'h07; dir_req = '0; ack_count = 0;
        run_frame("post_rst");
        check("post_rst_x0", 32'(pos_x[CW-1:0]), 321);
        check("post_rst_acks", ack_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
